// File: rtl/vga_pkg.sv
// Shared VGA constants, pixel format and loader state encoding.
// Used by the frame loader, the display reader and the VGA controller.
package vga_pkg;

    localparam int H_RES        = 640;
    localparam int V_RES        = 480;
    localparam int FRAME_PIXELS = H_RES * V_RES;
    localparam int ADDR_W       = 19;

    // RGB111 bit positions inside a pixel byte (00000RGB)
    localparam int R_BIT = 2;
    localparam int G_BIT = 1;
    localparam int B_BIT = 0;

    localparam logic [7:0] RGB_MASK = 8'((1 << R_BIT) | (1 << G_BIT) | (1 << B_BIT));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } loader_state_t;

    // Keep only the RGB bits of an incoming pixel byte
    function automatic logic [7:0] rgb_mask(input logic [7:0] pix_byte);
        return pix_byte & RGB_MASK;
    endfunction

endpackage

// File: rtl/frame_addr_counter.sv
// Raster-order x/y counter with a running linear address (y*H + x)
// built incrementally, so no multiplier is needed.
module frame_addr_counter
    import vga_pkg::*;
#(
    parameter int H_COUNT = H_RES,
    parameter int V_COUNT = V_RES
) (
    input  logic              clk_25mhz,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam int XW = $clog2(H_COUNT);
    localparam int YW = $clog2(V_COUNT);
    localparam logic [XW-1:0] X_LAST = XW'(H_COUNT - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_COUNT - 1);

    logic [XW-1:0]     x_r;
    logic [YW-1:0]     y_r;
    logic [ADDR_W-1:0] addr_r;
    logic              last_s;

    assign last_s = (x_r == X_LAST) && (y_r == Y_LAST);
    assign last   = last_s;
    assign addr   = addr_r;

    // Advance x/y/address by one pixel per increment; wrap the whole frame after the last pixel
    always_ff @(posedge clk_25mhz or negedge reset) begin
        if (!reset) begin
            x_r    <= {XW{1'b0}};
            y_r    <= {YW{1'b0}};
            addr_r <= {ADDR_W{1'b0}};
        end else if (clr) begin
            x_r    <= {XW{1'b0}};
            y_r    <= {YW{1'b0}};
            addr_r <= {ADDR_W{1'b0}};
        end else if (inc) begin
            if (last_s) begin
                x_r    <= {XW{1'b0}};
                y_r    <= {YW{1'b0}};
                addr_r <= {ADDR_W{1'b0}};
            end else if (x_r == X_LAST) begin
                x_r    <= {XW{1'b0}};
                y_r    <= y_r + YW'(1);
                addr_r <= addr_r + ADDR_W'(1);
            end else begin
                x_r    <= x_r + XW'(1);
                addr_r <= addr_r + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_frame_loader.sv
// Frame loader: streams RGB111 pixel bytes into the framebuffer BRAM write
// port in raster order, with start/abort/timeout control and sticky status.
module vga_frame_loader
    import vga_pkg::*;
#(
    parameter int H_RES          = vga_pkg::H_RES,
    parameter int V_RES          = vga_pkg::V_RES,
    parameter int TIMEOUT_CYCLES = 25_000_000
) (
    input  logic              clk_25mhz,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        bram_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] pixel_count
);

    localparam logic [ADDR_W-1:0] FRAME_CNT = ADDR_W'(H_RES * V_RES);
    localparam int                TO_W      = $clog2(TIMEOUT_CYCLES);
    // Transition is taken as the idle counter steps onto TIMEOUT_CYCLES-1,
    // so error shows exactly TIMEOUT_CYCLES cycles after the last accept.
    localparam logic [TO_W-1:0]   TO_HIT    = TO_W'(TIMEOUT_CYCLES - 2);

    loader_state_t     state_r;
    loader_state_t     next_state_s;
    logic              accept_s;
    logic              start_take_s;
    logic              timeout_s;
    logic              last_s;
    logic [ADDR_W-1:0] cur_addr_s;
    logic [TO_W-1:0]   timeout_cnt_r;

    logic              bram_we_r;
    logic [ADDR_W-1:0] bram_addr_r;
    logic [7:0]        bram_wdata_r;
    logic              busy_r;
    logic              done_r;
    logic              error_r;
    logic [ADDR_W-1:0] pixel_count_r;

    assign in_ready     = (state_r == LOAD);
    assign accept_s     = in_valid & in_ready;
    assign start_take_s = start & (state_r != LOAD);
    assign timeout_s    = (state_r == LOAD) & ~accept_s & (timeout_cnt_r == TO_HIT);

    assign bram_we      = bram_we_r;
    assign bram_addr    = bram_addr_r;
    assign bram_wdata   = bram_wdata_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = error_r;
    assign pixel_count  = pixel_count_r;

    frame_addr_counter #(
        .H_COUNT (H_RES),
        .V_COUNT (V_RES)
    ) u_addr_cnt (
        .clk_25mhz (clk_25mhz),
        .reset     (reset),
        .clr       (start_take_s),
        .inc       (accept_s),
        .addr      (cur_addr_s),
        .last      (last_s)
    );

    // Next-state logic; completion of the final pixel takes priority over abort/timeout
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                if (accept_s && last_s) begin
                    next_state_s = DONE;
                end else if (abort || timeout_s) begin
                    next_state_s = ERROR;
                end else begin
                    next_state_s = LOAD;
                end
            end
            DONE, ERROR: begin
                if (start) begin
                    next_state_s = LOAD;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register with status flags registered from the next state
    always_ff @(posedge clk_25mhz or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == LOAD);
            done_r  <= (next_state_s == DONE);
            error_r <= (next_state_s == ERROR);
        end
    end

    // Idle-cycle counter between accepted bytes while loading
    always_ff @(posedge clk_25mhz or negedge reset) begin
        if (!reset) begin
            timeout_cnt_r <= {TO_W{1'b0}};
        end else if (start_take_s || accept_s) begin
            timeout_cnt_r <= {TO_W{1'b0}};
        end else if (state_r == LOAD) begin
            timeout_cnt_r <= timeout_cnt_r + TO_W'(1);
        end
    end

    // One-cycle write pipeline: an accepted byte becomes a BRAM write next cycle
    always_ff @(posedge clk_25mhz or negedge reset) begin
        if (!reset) begin
            bram_we_r    <= 1'b0;
            bram_addr_r  <= {ADDR_W{1'b0}};
            bram_wdata_r <= 8'h00;
        end else begin
            bram_we_r <= accept_s;
            if (accept_s) begin
                bram_addr_r  <= cur_addr_s;
                bram_wdata_r <= rgb_mask(in_data);
            end
        end
    end

    // Pixels written in the current load, saturating at a full frame
    always_ff @(posedge clk_25mhz or negedge reset) begin
        if (!reset) begin
            pixel_count_r <= {ADDR_W{1'b0}};
        end else if (start_take_s) begin
            pixel_count_r <= {ADDR_W{1'b0}};
        end else if (accept_s && (pixel_count_r != FRAME_CNT)) begin
            pixel_count_r <= pixel_count_r + ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_vga_frame_loader.sv
// Directed bench for vga_frame_loader with a write scoreboard.
// Uses a reduced 640x4 frame and a 100-cycle timeout to keep runs short.
module tb_vga_frame_loader;

    localparam int H    = 640;
    localparam int V    = 4;
    localparam int TO   = 100;
    localparam int NPIX = H * V;

    logic        clk_25mhz = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        bram_we;
    logic [18:0] bram_addr;
    logic [7:0]  bram_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [18:0] pixel_count;

    typedef struct packed {
        logic [18:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  exp_addr = 0;
    int  exp_pc = 0;

    vga_frame_loader #(
        .H_RES          (H),
        .V_RES          (V),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_25mhz   (clk_25mhz),
        .reset       (rst_n),
        .start       (start),
        .abort       (abort),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .bram_we     (bram_we),
        .bram_addr   (bram_addr),
        .bram_wdata  (bram_wdata),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .pixel_count (pixel_count)
    );

    always #5 clk_25mhz = ~clk_25mhz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_25mhz);
        #1;
    endtask

    // Drive one byte for a cycle; the bench expects it to be accepted
    task automatic send(input logic [7:0] d);
        wr_t w;
        w.addr = 19'(exp_addr);
        w.data = d & 8'h07;
        exp_q.push_back(w);
        exp_addr++;
        exp_pc++;
        in_valid = 1'b1;
        in_data  = d;
        cyc();
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        exp_addr = 0;
        exp_pc   = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},    32'(in_ready),    32'd0);
        chk({tag, "_bram_we"},     32'(bram_we),     32'd0);
        chk({tag, "_bram_addr"},   32'(bram_addr),   32'd0);
        chk({tag, "_bram_wdata"},  32'(bram_wdata),  32'd0);
        chk({tag, "_busy"},        32'(busy),        32'd0);
        chk({tag, "_done"},        32'(done),        32'd0);
        chk({tag, "_error"},       32'(error),       32'd0);
        chk({tag, "_pixel_count"}, 32'(pixel_count), 32'd0);
    endtask

    // Scoreboard: every BRAM write must match the oldest expected write
    always @(negedge clk_25mhz) begin
        if (rst_n && bram_we) begin
            chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                wr_t w;
                w = exp_q.pop_front();
                chk("bram_addr", 32'(bram_addr), 32'(w.addr));
                chk("bram_wdata", 32'(bram_wdata), 32'(w.data));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk_25mhz);
        @(negedge clk_25mhz);
        chk_all_zero("reset");
        cyc();
        rst_n = 1'b1;
        cyc();

        // Bytes offered in IDLE are dropped
        in_valid = 1'b1;
        in_data  = 8'h05;
        repeat (3) begin
            cyc();
            @(negedge clk_25mhz);
            chk("idle_in_ready", 32'(in_ready), 32'd0);
            chk("idle_bram_we", 32'(bram_we), 32'd0);
        end
        in_valid = 1'b0;

        // Full frame, first two bytes exercise masking of the upper bits
        do_start();
        @(negedge clk_25mhz);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_in_ready", 32'(in_ready), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        chk("start_pc", 32'(pixel_count), 32'd0);
        send(8'hFF);
        send(8'hA5);
        for (int i = 2; i < NPIX; i++) send(8'(i % 8));
        in_valid = 1'b0;
        @(negedge clk_25mhz);
        chk("frame_done", 32'(done), 32'd1);
        chk("frame_busy", 32'(busy), 32'd0);
        chk("frame_error", 32'(error), 32'd0);
        chk("frame_pc", 32'(pixel_count), 32'(NPIX));
        chk("frame_in_ready", 32'(in_ready), 32'd0);

        // Bytes offered in DONE are dropped
        in_valid = 1'b1;
        in_data  = 8'h03;
        repeat (3) begin
            cyc();
            @(negedge clk_25mhz);
            chk("done_in_ready", 32'(in_ready), 32'd0);
            chk("done_bram_we", 32'(bram_we), 32'd0);
        end
        in_valid = 1'b0;

        // Restart; a start pulse during LOAD must not restart addressing
        do_start();
        for (int i = 0; i < 3; i++) send(8'(i));
        start = 1'b1;
        send(8'h03);
        start = 1'b0;
        for (int i = 4; i < 10; i++) send(8'(i));
        in_valid = 1'b0;
        @(negedge clk_25mhz);
        chk("ten_pc", 32'(pixel_count), 32'd10);
        chk("ten_busy", 32'(busy), 32'd1);

        // Timeout: error appears exactly TO cycles after the last accept
        repeat (TO - 2) cyc();
        @(negedge clk_25mhz);
        chk("pre_timeout_error", 32'(error), 32'd0);
        chk("pre_timeout_busy", 32'(busy), 32'd1);
        cyc();
        @(negedge clk_25mhz);
        chk("timeout_error", 32'(error), 32'd1);
        chk("timeout_busy", 32'(busy), 32'd0);
        chk("timeout_pc", 32'(pixel_count), 32'd10);
        chk("timeout_in_ready", 32'(in_ready), 32'd0);
        repeat (5) cyc();
        @(negedge clk_25mhz);
        chk("timeout_no_we", 32'(bram_we), 32'd0);

        // Abort together with the 641st byte: byte is written, then ERROR
        do_start();
        @(negedge clk_25mhz);
        chk("restart_error_clr", 32'(error), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 640; i++) send(8'(i % 8));
        abort = 1'b1;
        send(8'h06);
        abort = 1'b0;
        in_valid = 1'b0;
        @(negedge clk_25mhz);
        chk("abort_error", 32'(error), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_pc", 32'(pixel_count), 32'd641);

        // Start and abort together in ERROR restart the load
        start = 1'b1;
        abort = 1'b1;
        cyc();
        start = 1'b0;
        abort = 1'b0;
        exp_addr = 0;
        exp_pc   = 0;
        @(negedge clk_25mhz);
        chk("startabort_busy", 32'(busy), 32'd1);
        chk("startabort_error", 32'(error), 32'd0);
        for (int i = 0; i < 5; i++) send(8'(i + 1));
        in_valid = 1'b0;
        cyc();
        @(negedge clk_25mhz);
        chk("five_pc", 32'(pixel_count), 32'd5);

        // Abort on the final pixel: completion wins
        for (int i = 5; i < NPIX - 1; i++) send(8'(i % 8));
        abort = 1'b1;
        send(8'h07);
        abort = 1'b0;
        in_valid = 1'b0;
        @(negedge clk_25mhz);
        chk("lastabort_done", 32'(done), 32'd1);
        chk("lastabort_error", 32'(error), 32'd0);
        chk("lastabort_busy", 32'(busy), 32'd0);
        chk("lastabort_pc", 32'(pixel_count), 32'(NPIX));

        // Abort in DONE is ignored
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        cyc();
        @(negedge clk_25mhz);
        chk("doneabort_done", 32'(done), 32'd1);
        chk("doneabort_error", 32'(error), 32'd0);

        // Reset asserted mid-load after 1000 pixels, with a byte pending
        do_start();
        for (int i = 0; i < 1000; i++) send(8'(i % 8));
        in_valid = 1'b1;
        in_data  = 8'h02;
        @(negedge clk_25mhz);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (2) cyc();
        in_valid = 1'b0;
        rst_n = 1'b1;
        cyc();
        @(negedge clk_25mhz);
        chk("post_reset_in_ready", 32'(in_ready), 32'd0);
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_pc", 32'(pixel_count), 32'd0);

        // New load after reset starts again at address 0
        do_start();
        for (int i = 0; i < 3; i++) send(8'(i + 4));
        in_valid = 1'b0;
        repeat (2) cyc();
        @(negedge clk_25mhz);
        chk("final_pc", 32'(pixel_count), 32'(exp_pc));
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
